// File: rtl/scpad_frontend_arb_if.sv
// rtl/scpad_frontend_arb_if.sv - request/response bundle shared by requesters, SRAM control and the frontend arbiter
interface scpad_frontend_arb_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 256
);
    logic              vc_req_valid;
    logic              vc_req_ready;
    logic              vc_req_write;
    logic [ADDR_W-1:0] vc_req_addr;
    logic [DATA_W-1:0] vc_req_wdata;

    logic              sa_req_valid;
    logic              sa_req_ready;
    logic              sa_req_write;
    logic [ADDR_W-1:0] sa_req_addr;
    logic [DATA_W-1:0] sa_req_wdata;

    logic              sram_req_valid;
    logic              sram_req_ready;
    logic              sram_req_src;
    logic              sram_req_write;
    logic [ADDR_W-1:0] sram_req_addr;
    logic [DATA_W-1:0] sram_req_wdata;

    logic              sram_res_valid;
    logic [DATA_W-1:0] sram_res_rdata;

    logic              vc_res_valid;
    logic              vc_res_complete;
    logic [DATA_W-1:0] vc_res_rdata;
    logic              sa_res_valid;
    logic              sa_res_complete;
    logic [DATA_W-1:0] sa_res_rdata;

    logic              err_unexp_res;

    // Arbiter side
    modport slave (
        input  vc_req_valid, vc_req_write, vc_req_addr, vc_req_wdata,
        output vc_req_ready,
        input  sa_req_valid, sa_req_write, sa_req_addr, sa_req_wdata,
        output sa_req_ready,
        output sram_req_valid, sram_req_src, sram_req_write, sram_req_addr, sram_req_wdata,
        input  sram_req_ready,
        input  sram_res_valid, sram_res_rdata,
        output vc_res_valid, vc_res_complete, vc_res_rdata,
        output sa_res_valid, sa_res_complete, sa_res_rdata,
        output err_unexp_res
    );

    // Requester / SRAM-control side
    modport master (
        output vc_req_valid, vc_req_write, vc_req_addr, vc_req_wdata,
        input  vc_req_ready,
        output sa_req_valid, sa_req_write, sa_req_addr, sa_req_wdata,
        input  sa_req_ready,
        input  sram_req_valid, sram_req_src, sram_req_write, sram_req_addr, sram_req_wdata,
        output sram_req_ready,
        output sram_res_valid, sram_res_rdata,
        input  vc_res_valid, vc_res_complete, vc_res_rdata,
        input  sa_res_valid, sa_res_complete, sa_res_rdata,
        input  err_unexp_res
    );
endinterface

// File: rtl/scpad_frontend_arb.sv
// rtl/scpad_frontend_arb.sv - VC/SA request arbiter in front of scratchpad SRAM control with in-order response routing
// Optional performance counters are built when SCPAD_ARB_PERF_EN is defined.
module scpad_frontend_arb #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 256,
    parameter int REQ_DEPTH    = 4,
    parameter int TAG_DEPTH    = 8,
    parameter int STARVE_LIMIT = 8
) (
    input  logic clk,
    input  logic rst,
    scpad_frontend_arb_if.slave bus
`ifdef SCPAD_ARB_PERF_EN
    ,
    output logic [31:0] perf_vc_grants,
    output logic [31:0] perf_sa_grants,
    output logic [31:0] perf_stall_cycles
`endif
);
    localparam int RP_W  = $clog2(REQ_DEPTH);
    localparam int TP_W  = $clog2(TAG_DEPTH);
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
    localparam int ENT_W = 1 + ADDR_W + DATA_W;
    localparam logic [SC_W-1:0]   STARVE_MAX = SC_W'(STARVE_LIMIT);
    localparam logic [TP_W+1:0]   TAG_CAP    = (TP_W+2)'(TAG_DEPTH);

    // Index 0 is the vector core, index 1 the systolic array; matches sram_req_src.
    logic [1:0]       push;
    logic [1:0]       pop;
    logic [1:0]       not_empty;
    logic [1:0]       full;
    logic [ENT_W-1:0] push_data [2];
    logic [ENT_W-1:0] head      [2];

    assign push_data[0] = {bus.vc_req_write, bus.vc_req_addr, bus.vc_req_wdata};
    assign push_data[1] = {bus.sa_req_write, bus.sa_req_addr, bus.sa_req_wdata};

    assign bus.vc_req_ready = !rst && !full[0];
    assign bus.sa_req_ready = !rst && !full[1];
    assign push[0] = bus.vc_req_valid && bus.vc_req_ready;
    assign push[1] = bus.sa_req_valid && bus.sa_req_ready;

    for (genvar r = 0; r < 2; r++) begin : g_req_fifo
        logic [ENT_W-1:0] mem [REQ_DEPTH];
        logic [RP_W:0]    wr_ptr;
        logic [RP_W:0]    rd_ptr;

        assign not_empty[r] = (wr_ptr != rd_ptr);
        assign full[r]      = (wr_ptr[RP_W] != rd_ptr[RP_W]) &&
                              (wr_ptr[RP_W-1:0] == rd_ptr[RP_W-1:0]);
        assign head[r]      = mem[rd_ptr[RP_W-1:0]];

        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push[r]) wr_ptr <= wr_ptr + 1'b1;
                if (pop[r])  rd_ptr <= rd_ptr + 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (push[r]) mem[wr_ptr[RP_W-1:0]] <= push_data[r];
        end
    end

    // Outstanding-request tags: {src, write} per issued request, oldest at the head.
    logic [1:0]    tag_mem [TAG_DEPTH];
    logic [TP_W:0] tag_wr;
    logic [TP_W:0] tag_rd;
    logic [TP_W:0] tag_cnt;
    logic [TP_W+1:0] tag_occ_next;
    logic [1:0]    tag_head;
    logic          tag_empty;
    logic          tag_ok;

    logic              req_valid_q;
    logic              req_src_q;
    logic              req_write_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [DATA_W-1:0] req_wdata_q;
    logic [SC_W-1:0]   starve_cnt;

    logic hs;
    logic res_pop;
    logic out_free;
    logic grant;
    logic sa_win;

    assign hs        = req_valid_q && bus.sram_req_ready;
    assign tag_cnt   = tag_wr - tag_rd;
    assign tag_empty = (tag_cnt == '0);
    assign tag_head  = tag_mem[tag_rd[TP_W-1:0]];
    assign res_pop   = bus.sram_res_valid && !tag_empty;

    // A new grant will need a tag slot when it is later handshaken, so leave one free after this cycle.
    assign tag_occ_next = {1'b0, tag_cnt} + (TP_W+2)'(hs) - (TP_W+2)'(res_pop);
    assign tag_ok       = (tag_occ_next < TAG_CAP);

    assign out_free = !req_valid_q || bus.sram_req_ready;
    assign grant    = out_free && tag_ok && (not_empty != 2'b00);
    assign sa_win   = not_empty[1] && (!not_empty[0] || starve_cnt == STARVE_MAX);
    assign pop[0]   = grant && !sa_win;
    assign pop[1]   = grant && sa_win;

    always_ff @(posedge clk) begin
        if (rst) begin
            req_valid_q <= 1'b0;
            req_src_q   <= 1'b0;
            req_write_q <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
        end else if (out_free) begin
            req_valid_q <= grant;
            if (grant) begin
                req_src_q <= sa_win;
                {req_write_q, req_addr_q, req_wdata_q} <= sa_win ? head[1] : head[0];
            end
        end
    end

    assign bus.sram_req_valid = req_valid_q;
    assign bus.sram_req_src   = req_src_q;
    assign bus.sram_req_write = req_write_q;
    assign bus.sram_req_addr  = req_addr_q;
    assign bus.sram_req_wdata = req_wdata_q;

    // Counts VC wins only while SA is actually waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!not_empty[1] || pop[1]) begin
            starve_cnt <= '0;
        end else if (pop[0] && starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_wr <= '0;
            tag_rd <= '0;
        end else begin
            if (hs)      tag_wr <= tag_wr + 1'b1;
            if (res_pop) tag_rd <= tag_rd + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (hs) tag_mem[tag_wr[TP_W-1:0]] <= {req_src_q, req_write_q};
    end

    logic              vc_res_valid_q;
    logic              vc_res_complete_q;
    logic [DATA_W-1:0] vc_res_rdata_q;
    logic              sa_res_valid_q;
    logic              sa_res_complete_q;
    logic [DATA_W-1:0] sa_res_rdata_q;
    logic              err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vc_res_valid_q    <= 1'b0;
            vc_res_complete_q <= 1'b0;
            vc_res_rdata_q    <= '0;
            sa_res_valid_q    <= 1'b0;
            sa_res_complete_q <= 1'b0;
            sa_res_rdata_q    <= '0;
            err_q             <= 1'b0;
        end else begin
            vc_res_valid_q    <= res_pop && !tag_head[1];
            vc_res_complete_q <= res_pop && !tag_head[1] && tag_head[0];
            sa_res_valid_q    <= res_pop && tag_head[1];
            sa_res_complete_q <= res_pop && tag_head[1] && tag_head[0];
            if (res_pop && !tag_head[1]) vc_res_rdata_q <= bus.sram_res_rdata;
            if (res_pop && tag_head[1])  sa_res_rdata_q <= bus.sram_res_rdata;
            if (bus.sram_res_valid && tag_empty) err_q <= 1'b1;
        end
    end

    assign bus.vc_res_valid    = vc_res_valid_q;
    assign bus.vc_res_complete = vc_res_complete_q;
    assign bus.vc_res_rdata    = vc_res_rdata_q;
    assign bus.sa_res_valid    = sa_res_valid_q;
    assign bus.sa_res_complete = sa_res_complete_q;
    assign bus.sa_res_rdata    = sa_res_rdata_q;
    assign bus.err_unexp_res   = err_q;

`ifdef SCPAD_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_vc_grants    <= '0;
            perf_sa_grants    <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (hs && !req_src_q && perf_vc_grants != '1) perf_vc_grants <= perf_vc_grants + 1'b1;
            if (hs && req_src_q && perf_sa_grants != '1)  perf_sa_grants <= perf_sa_grants + 1'b1;
            if (req_valid_q && !bus.sram_req_ready && perf_stall_cycles != '1)
                perf_stall_cycles <= perf_stall_cycles + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_scpad_frontend_arb.sv
// tb/tb_scpad_frontend_arb.sv - self-checking bench for scpad_frontend_arb
module tb_scpad_frontend_arb;
    localparam int ADDR_W = 16, DATA_W = 256, REQ_DEPTH = 4, TAG_DEPTH = 8, STARVE_LIMIT = 8;
    localparam int CW = 512;

    typedef struct {
        logic              src;
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    scpad_frontend_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
`ifdef SCPAD_ARB_PERF_EN
    logic [31:0] perf_vc, perf_sa, perf_st;
`endif

    scpad_frontend_arb #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .REQ_DEPTH(REQ_DEPTH),
        .TAG_DEPTH(TAG_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
`ifdef SCPAD_ARB_PERF_EN
        ,
        .perf_vc_grants(perf_vc),
        .perf_sa_grants(perf_sa),
        .perf_stall_cycles(perf_st)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Event logs filled by the monitor; the checker walks them with its own indices.
    req_t              acc_vc[$];
    req_t              acc_sa[$];
    req_t              hs_log[$];
    req_t              res_out_log[$];
    logic [DATA_W-1:0] res_in_log[$];
    int                out_cnt = 0;

    int  hs_i = 0, vc_i = 0, sa_i = 0, rout_i = 0;
    bit  auto_vc = 0, auto_sa = 0, rand_req = 0, auto_rdy = 0, auto_res = 0;
    int  res_pct = 100;

    always @(negedge clk) begin
        if (rst) begin
            out_cnt = 0;
        end else begin
            if (bus.vc_req_valid && bus.vc_req_ready)
                acc_vc.push_back('{1'b0, bus.vc_req_write, bus.vc_req_addr, bus.vc_req_wdata});
            if (bus.sa_req_valid && bus.sa_req_ready)
                acc_sa.push_back('{1'b1, bus.sa_req_write, bus.sa_req_addr, bus.sa_req_wdata});
            if (bus.vc_res_valid)
                res_out_log.push_back('{1'b0, bus.vc_res_complete, {ADDR_W{1'b0}}, bus.vc_res_rdata});
            if (bus.sa_res_valid)
                res_out_log.push_back('{1'b1, bus.sa_res_complete, {ADDR_W{1'b0}}, bus.sa_res_rdata});
            if (bus.sram_res_valid && out_cnt > 0) begin
                res_in_log.push_back(bus.sram_res_rdata);
                out_cnt--;
            end
            if (bus.sram_req_valid && bus.sram_req_ready) begin
                hs_log.push_back('{bus.sram_req_src, bus.sram_req_write, bus.sram_req_addr, bus.sram_req_wdata});
                out_cnt++;
            end
        end
    end

    function automatic logic [DATA_W-1:0] rnd_data();
        logic [DATA_W-1:0] d;
        for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_vc || rand_req) begin
            bus.vc_req_valid = auto_vc ? 1'b1 : 1'($urandom_range(0, 1));
            bus.vc_req_write = 1'($urandom_range(0, 1));
            bus.vc_req_addr  = ADDR_W'($urandom);
            bus.vc_req_wdata = rnd_data();
        end
        if (auto_sa || rand_req) begin
            bus.sa_req_valid = auto_sa ? 1'b1 : 1'($urandom_range(0, 1));
            bus.sa_req_write = 1'($urandom_range(0, 1));
            bus.sa_req_addr  = ADDR_W'($urandom);
            bus.sa_req_wdata = rnd_data();
        end
        if (auto_rdy) bus.sram_req_ready = ($urandom_range(0, 3) != 0);
        if (auto_res) begin
            bus.sram_res_valid = (out_cnt > 0) && ($urandom_range(0, 99) < res_pct);
            bus.sram_res_rdata = rnd_data();
        end
    endtask

    task automatic send(input bit s, input bit wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bit acc;
        int n = 0;
        if (s) begin
            bus.sa_req_valid = 1; bus.sa_req_write = wr; bus.sa_req_addr = a; bus.sa_req_wdata = d;
        end else begin
            bus.vc_req_valid = 1; bus.vc_req_write = wr; bus.vc_req_addr = a; bus.vc_req_wdata = d;
        end
        do begin
            acc = s ? bus.sa_req_ready : bus.vc_req_ready;
            tick();
            n++;
        end while (!acc && n < 50);
        chk("send_accepted", CW'(acc), CW'(1));
        if (s) bus.sa_req_valid = 0; else bus.vc_req_valid = 0;
    endtask

    // Issued requests must match each source's accepted requests in order; responses follow issue order.
    task automatic check_logs();
        while (hs_i < hs_log.size()) begin
            req_t h = hs_log[hs_i];
            if (!h.src) begin
                chk("hs_vc_known", CW'(vc_i < acc_vc.size()), CW'(1));
                if (vc_i < acc_vc.size()) begin
                    chk("hs_vc_data", CW'({h.write, h.addr, h.wdata}),
                        CW'({acc_vc[vc_i].write, acc_vc[vc_i].addr, acc_vc[vc_i].wdata}));
                    vc_i++;
                end
            end else begin
                chk("hs_sa_known", CW'(sa_i < acc_sa.size()), CW'(1));
                if (sa_i < acc_sa.size()) begin
                    chk("hs_sa_data", CW'({h.write, h.addr, h.wdata}),
                        CW'({acc_sa[sa_i].write, acc_sa[sa_i].addr, acc_sa[sa_i].wdata}));
                    sa_i++;
                end
            end
            hs_i++;
        end
        while (rout_i < res_out_log.size()) begin
            req_t o = res_out_log[rout_i];
            bit known = (rout_i < hs_log.size()) && (rout_i < res_in_log.size());
            chk("res_known", CW'(known), CW'(1));
            if (known) begin
                chk("res_port", CW'(o.src), CW'(hs_log[rout_i].src));
                chk("res_complete", CW'(o.write), CW'(hs_log[rout_i].write));
                chk("res_rdata", CW'(o.wdata), CW'(res_in_log[rout_i]));
            end
            rout_i++;
        end
    endtask

    initial begin
        int base;
        logic [CW-1:0] snap;

        bus.vc_req_valid = 0; bus.vc_req_write = 0; bus.vc_req_addr = '0; bus.vc_req_wdata = '0;
        bus.sa_req_valid = 0; bus.sa_req_write = 0; bus.sa_req_addr = '0; bus.sa_req_wdata = '0;
        bus.sram_req_ready = 0; bus.sram_res_valid = 0; bus.sram_res_rdata = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_vc_ready", CW'(bus.vc_req_ready), CW'(0));
        chk("rst_sa_ready", CW'(bus.sa_req_ready), CW'(0));
        chk("rst_req_valid", CW'(bus.sram_req_valid), CW'(0));
        chk("rst_res_valid", CW'({bus.vc_res_valid, bus.sa_res_valid}), CW'(0));
        chk("rst_err", CW'(bus.err_unexp_res), CW'(0));
        rst = 0;
        tick();
        chk("post_rst_ready", CW'({bus.vc_req_ready, bus.sa_req_ready}), CW'(2'b11));

        // Single VC read: latency and response routing
        bus.sram_req_ready = 1;
        bus.vc_req_valid = 1; bus.vc_req_write = 0; bus.vc_req_addr = 16'h0010; bus.vc_req_wdata = rnd_data();
        tick();
        bus.vc_req_valid = 0;
        chk("lat_accept_edge", CW'(bus.sram_req_valid), CW'(0));
        tick();
        chk("lat_valid", CW'(bus.sram_req_valid), CW'(1));
        chk("lat_src_wr_addr", CW'({bus.sram_req_src, bus.sram_req_write, bus.sram_req_addr}), CW'({2'b00, 16'h0010}));
        tick();
        chk("lat_handshaken", CW'(bus.sram_req_valid), CW'(0));
        bus.sram_res_valid = 1;
        bus.sram_res_rdata = {(DATA_W/8){8'hA5}};
        chk("res_not_early", CW'(bus.vc_res_valid), CW'(0));
        tick();
        bus.sram_res_valid = 0;
        chk("res_vc_valid", CW'(bus.vc_res_valid), CW'(1));
        chk("res_vc_complete", CW'(bus.vc_res_complete), CW'(0));
        chk("res_vc_rdata", CW'(bus.vc_res_rdata), CW'({(DATA_W/8){8'hA5}}));
        chk("res_sa_quiet", CW'(bus.sa_res_valid), CW'(0));
        tick();
        chk("res_one_cycle", CW'(bus.vc_res_valid), CW'(0));

        // Starvation: both FIFOs kept full -> STARVE_LIMIT VC grants then one SA grant
        base = hs_log.size();
        auto_res = 1; res_pct = 100; auto_vc = 1; auto_sa = 1;
        repeat (60) tick();
        chk("starve_enough", CW'(hs_log.size() >= base + 27), CW'(1));
        for (int i = 0; i < 27 && base + i < hs_log.size(); i++)
            chk($sformatf("starve_seq%0d", i), CW'(hs_log[base+i].src), CW'((i % (STARVE_LIMIT+1)) == STARVE_LIMIT));
        // Drain SA while VC keeps winning, then restart both from idle
        auto_sa = 0; bus.sa_req_valid = 0;
        repeat (60) tick();
        auto_vc = 0; bus.vc_req_valid = 0;
        repeat (15) tick();
        base = hs_log.size();
        auto_vc = 1; auto_sa = 1;
        repeat (40) tick();
        auto_vc = 0; auto_sa = 0; bus.vc_req_valid = 0; bus.sa_req_valid = 0;
        chk("restart_enough", CW'(hs_log.size() >= base + 18), CW'(1));
        for (int i = 0; i < 18 && base + i < hs_log.size(); i++)
            chk($sformatf("restart_seq%0d", i), CW'(hs_log[base+i].src), CW'((i % (STARVE_LIMIT+1)) == STARVE_LIMIT));
        repeat (30) tick();
        auto_res = 0; bus.sram_res_valid = 0;
        tick();
        check_logs();

        // Back-pressure: held SA write stays stable while VC FIFO fills
        bus.sram_req_ready = 0;
        base = hs_log.size();
        bus.sa_req_valid = 1; bus.sa_req_write = 1; bus.sa_req_addr = 16'h0ABC; bus.sa_req_wdata = rnd_data();
        tick();
        bus.sa_req_valid = 0;
        tick();
        chk("stall_loaded", CW'({bus.sram_req_valid, bus.sram_req_src, bus.sram_req_write, bus.sram_req_addr}),
            CW'({3'b111, 16'h0ABC}));
        snap = CW'({bus.sram_req_src, bus.sram_req_write, bus.sram_req_addr, bus.sram_req_wdata});
        auto_vc = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("stall_hold%0d", i),
                CW'({bus.sram_req_src, bus.sram_req_write, bus.sram_req_addr, bus.sram_req_wdata}), snap);
            chk($sformatf("stall_valid%0d", i), CW'(bus.sram_req_valid), CW'(1));
        end
        chk("vc_fifo_full", CW'(bus.vc_req_ready), CW'(0));
        auto_vc = 0; bus.vc_req_valid = 0;
        bus.sram_req_ready = 1;
        repeat (10) tick();
        chk("drain_count", CW'(hs_log.size() - base), CW'(5));
        if (hs_log.size() > base) chk("drain_sa_first", CW'(hs_log[base].src), CW'(1));
        auto_res = 1;
        repeat (12) tick();
        auto_res = 0; bus.sram_res_valid = 0;
        tick();
        check_logs();

        // Tag FIFO full: 9th request waits for a response
        base = hs_log.size();
        for (int n = 0; n < 9; n++) send(n % 2, n % 3 == 0, ADDR_W'(16'h0100 + n), rnd_data());
        repeat (8) tick();
        chk("tag_full_issued", CW'(hs_log.size() - base), CW'(TAG_DEPTH));
        chk("tag_full_stall", CW'(bus.sram_req_valid), CW'(0));
        bus.sram_res_valid = 1; bus.sram_res_rdata = rnd_data();
        tick();
        bus.sram_res_valid = 0;
        chk("tag_free_grant", CW'(bus.sram_req_valid), CW'(1));
        auto_res = 1;
        repeat (25) tick();
        auto_res = 0; bus.sram_res_valid = 0;
        tick();
        check_logs();

        // Randomized traffic with random back-pressure and response timing
        rand_req = 1; auto_rdy = 1; auto_res = 1; res_pct = 50;
        repeat (400) tick();
        rand_req = 0; bus.vc_req_valid = 0; bus.sa_req_valid = 0;
        auto_rdy = 0; bus.sram_req_ready = 1; res_pct = 100;
        repeat (40) tick();
        auto_res = 0; bus.sram_res_valid = 0;
        repeat (2) tick();
        check_logs();
        chk("all_issued", CW'(hs_log.size()), CW'(acc_vc.size() + acc_sa.size()));
        chk("all_answered", CW'(res_out_log.size()), CW'(hs_log.size()));

        // Unexpected response
        chk("err_clear", CW'(bus.err_unexp_res), CW'(0));
        bus.sram_res_valid = 1;
        tick();
        bus.sram_res_valid = 0;
        chk("unexp_no_res", CW'({bus.vc_res_valid, bus.sa_res_valid}), CW'(0));
        chk("unexp_err", CW'(bus.err_unexp_res), CW'(1));
        repeat (3) tick();
        chk("unexp_err_sticky", CW'(bus.err_unexp_res), CW'(1));

        // Reset mid-operation discards queued work; a response right after reset is unexpected
        bus.sram_req_ready = 0;
        send(0, 0, 16'h0200, rnd_data());
        send(0, 1, 16'h0201, rnd_data());
        send(1, 0, 16'h0202, rnd_data());
        tick();
        chk("midop_pending", CW'(bus.sram_req_valid), CW'(1));
        rst = 1;
        tick();
        chk("midop_rst_valid", CW'(bus.sram_req_valid), CW'(0));
        chk("midop_rst_err", CW'(bus.err_unexp_res), CW'(0));
        rst = 0;
        bus.sram_req_ready = 1;
        base = hs_log.size();
        repeat (5) tick();
        chk("midop_discard", CW'(hs_log.size() - base), CW'(0));
        chk("midop_idle", CW'(bus.sram_req_valid), CW'(0));
        bus.sram_res_valid = 1;
        tick();
        bus.sram_res_valid = 0;
        chk("post_rst_unexp", CW'(bus.err_unexp_res), CW'(1));
        rst = 1;
        tick();
        rst = 0;
        tick();

`ifdef SCPAD_ARB_PERF_EN
        bus.sram_req_ready = 1;
        send(0, 0, 16'h0300, rnd_data());
        send(0, 1, 16'h0301, rnd_data());
        send(1, 0, 16'h0302, rnd_data());
        send(1, 1, 16'h0303, rnd_data());
        repeat (4) tick();
        bus.sram_req_ready = 0;
        send(0, 0, 16'h0304, rnd_data());
        tick();
        repeat (4) tick();
        bus.sram_req_ready = 1;
        repeat (3) tick();
        chk("perf_vc", CW'(perf_vc), CW'(3));
        chk("perf_sa", CW'(perf_sa), CW'(2));
        chk("perf_stall", CW'(perf_st), CW'(4));
        rst = 1;
        tick();
        rst = 0;
        chk("perf_rst", CW'({perf_vc, perf_sa, perf_st}), CW'(0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
